// File: rtl/bitonic_sorter_iter.sv
// bitonic_sorter_iter: iterative bitonic sorter reusing one row of NUM_COUNT/2
// compare-exchange units across all network stages, with IDLE/SORT/DONE handshake.
module bitonic_sorter_iter #(
    parameter int NUM_COUNT  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_COUNT*DATA_WIDTH-1:0] data_in,
    input  logic                            valid,
    input  logic                            descending,
    output logic                            ready,
    output logic [NUM_COUNT*DATA_WIDTH-1:0] data_out,
    output logic                            done,
    input  logic                            out_ack
);
    localparam int L  = $clog2(NUM_COUNT);
    localparam int CW = (L > 1) ? $clog2(L) : 1;
    localparam logic [CW-1:0] LAST = CW'(L - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SORT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (NUM_COUNT < 2 || (NUM_COUNT & (NUM_COUNT - 1)) != 0) begin : g_bad_count
        $error("NUM_COUNT must be a power of two >= 2");
    end

    logic [1:0]                      state_q, state_d;
    logic [NUM_COUNT*DATA_WIDTH-1:0] data_q, data_d, net;
    logic [CW-1:0]                   p_q, p_d, q_q, q_d;
    logic                            desc_q, desc_d;
    int                              lo, hi;
    logic [DATA_WIDTH-1:0]           a, b;
    logic                            sw;

    assign ready    = (state_q == IDLE) & ~reset;
    assign done     = state_q == DONE;
    assign data_out = data_q;

    // Stage (k = 2<<p, j = 1<<q): unit u handles lo = u with a zero inserted at bit q.
    always_comb begin
        net = data_q;
        lo  = 0;
        hi  = 0;
        a   = '0;
        b   = '0;
        sw  = 1'b0;
        for (int u = 0; u < NUM_COUNT / 2; u++) begin
            lo = ((u >> q_q) << (int'(q_q) + 1)) | (u & ((1 << q_q) - 1));
            hi = lo | (1 << q_q);
            a  = data_q[lo*DATA_WIDTH +: DATA_WIDTH];
            b  = data_q[hi*DATA_WIDTH +: DATA_WIDTH];
            sw = ((((lo >> (int'(p_q) + 1)) & 1) != 0) ^ desc_q) ? (b > a) : (a > b);
            net[lo*DATA_WIDTH +: DATA_WIDTH] = sw ? b : a;
            net[hi*DATA_WIDTH +: DATA_WIDTH] = sw ? a : b;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        p_d     = p_q;
        q_d     = q_q;
        desc_d  = desc_q;
        if (state_q == IDLE && valid) begin
            data_d  = data_in;
            desc_d  = descending;
            p_d     = '0;
            q_d     = '0;
            state_d = SORT;
        end else if (state_q == SORT) begin
            data_d  = net;
            state_d = (q_q == '0 && p_q == LAST) ? DONE : SORT;
            p_d     = (q_q == '0 && p_q != LAST) ? p_q + 1'b1 : p_q;
            q_d     = (q_q == '0) ? ((p_q != LAST) ? p_q + 1'b1 : q_q) : q_q - 1'b1;
        end else if (state_q == DONE && out_ack) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            p_q     <= '0;
            q_q     <= '0;
            desc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            p_q     <= p_d;
            q_q     <= q_d;
            desc_q  <= desc_d;
        end
    end
endmodule

// File: tb/tb_bitonic_sorter_iter.sv
// tb_bitonic_sorter_iter: directed checks on a 4-element sorter plus a
// streaming run on an 8-element sorter against a reference sort.
module tb_bitonic_sorter_iter;
    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] din4 = '0, dout4;
    logic        v4 = 1'b0, d4 = 1'b0, a4 = 1'b0, rdy4, dn4;
    logic [63:0] din8 = '0, dout8;
    logic        v8 = 1'b0, d8 = 1'b0, a8 = 1'b0, rdy8, dn8;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    bitonic_sorter_iter #(.NUM_COUNT(4), .DATA_WIDTH(8)) u_dut4 (
        .clk(clk), .reset(reset), .data_in(din4), .valid(v4), .descending(d4),
        .ready(rdy4), .data_out(dout4), .done(dn4), .out_ack(a4));

    bitonic_sorter_iter #(.NUM_COUNT(8), .DATA_WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .data_in(din8), .valid(v8), .descending(d8),
        .ready(rdy8), .data_out(dout8), .done(dn8), .out_ack(a8));

    function automatic logic [31:0] p4(input int e0, input int e1, input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    function automatic logic [63:0] ref8(input logic [63:0] x, input logic desc);
        logic [7:0] e[8];
        logic [7:0] t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) e[i] = x[i*8 +: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (desc ? (e[j] < e[j+1]) : (e[j] > e[j+1])) begin
                    t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                end
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = e[i];
        return r;
    endfunction

    function automatic logic [63:0] mk8(input int b);
        logic [63:0] x;
        for (int i = 0; i < 8; i++) x[i*8 +: 8] = 8'($urandom_range(0, 255));
        if (b % 4 == 0) begin
            x[(b % 8)*8 +: 8]       = 8'd0;
            x[((b + 3) % 8)*8 +: 8] = 8'd255;
        end
        return x;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic sort4(input logic [31:0] din, input logic desc, output int lat);
        v4 = 1'b1; din4 = din; d4 = desc;
        step;
        v4 = 1'b0; din4 = '0; lat = 0;
        while (!dn4 && lat < 20) begin
            step;
            lat++;
        end
    endtask

    task automatic ack4;
        a4 = 1'b1;
        step;
        a4 = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", rdy4); end
        total++; if (dn4 !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", dn4); end
        total++; if (dout4 !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", dout4); end
        total++; if (rdy8 !== 1'b0) begin bad++; $display("FAIL rst_ready8 got=%b want=0", rdy8); end
        step; step;
        reset = 1'b0;
        #1;
        total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL rst_idle_ready got=%b want=1", rdy4); end
        total++; if (dn4 !== 1'b0) begin bad++; $display("FAIL rst_idle_done got=%b want=0", dn4); end
        step;
    endtask

    task automatic test_ascending;
        v4 = 1'b1; din4 = p4(3, 1, 4, 2); d4 = 1'b0;
        step;
        v4 = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL asc_ready c%0d got=%b want=0", e, rdy4); end
            total++; if (dn4 !== 1'b0) begin bad++; $display("FAIL asc_early c%0d got=%b want=0", e, dn4); end
            step;
        end
        total++; if (dn4 !== 1'b1) begin bad++; $display("FAIL asc_done got=%b want=1", dn4); end
        total++; if (dout4 !== p4(1, 2, 3, 4)) begin bad++; $display("FAIL asc_data got=%h want=%h", dout4, p4(1, 2, 3, 4)); end
        total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL asc_done_ready got=%b want=0", rdy4); end
        ack4;
        total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL asc_ack_ready got=%b want=1", rdy4); end
        total++; if (dn4 !== 1'b0) begin bad++; $display("FAIL asc_ack_done got=%b want=0", dn4); end
    endtask

    task automatic test_back_to_back;
        int lat;
        sort4(p4(3, 1, 4, 2), 1'b1, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL desc_latency got=%0d want=3", lat); end
        total++; if (dout4 !== p4(4, 3, 2, 1)) begin bad++; $display("FAIL desc_data got=%h want=%h", dout4, p4(4, 3, 2, 1)); end
        ack4;
        sort4(p4(9, 0, 9, 7), 1'b0, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL b2b_latency got=%0d want=3", lat); end
        total++; if (dout4 !== p4(0, 7, 9, 9)) begin bad++; $display("FAIL b2b_data got=%h want=%h", dout4, p4(0, 7, 9, 9)); end
        ack4;
    endtask

    task automatic test_equal;
        int lat;
        sort4(p4(5, 5, 0, 255), 1'b0, lat);
        total++; if (dout4 !== p4(0, 5, 5, 255)) begin bad++; $display("FAIL eq_bounds got=%h want=%h", dout4, p4(0, 5, 5, 255)); end
        ack4;
        sort4(p4(8, 8, 8, 8), 1'b0, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL eq_latency got=%0d want=3", lat); end
        total++; if (dout4 !== p4(8, 8, 8, 8)) begin bad++; $display("FAIL eq_all got=%h want=%h", dout4, p4(8, 8, 8, 8)); end
        ack4;
    endtask

    task automatic test_stall;
        int lat;
        sort4(p4(2, 3, 1, 0), 1'b1, lat);
        v4 = 1'b1; din4 = p4(7, 6, 5, 4); d4 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step;
            total++; if (dn4 !== 1'b1) begin bad++; $display("FAIL stall_done c%0d got=%b want=1", c, dn4); end
            total++; if (dout4 !== p4(3, 2, 1, 0)) begin bad++; $display("FAIL stall_data c%0d got=%h want=%h", c, dout4, p4(3, 2, 1, 0)); end
            total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL stall_ready c%0d got=%b want=0", c, rdy4); end
        end
        v4 = 1'b0;
        ack4;
        total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL stall_ack_ready got=%b want=1", rdy4); end
        total++; if (dn4 !== 1'b0) begin bad++; $display("FAIL stall_ack_done got=%b want=0", dn4); end
        step;
        total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL stall_idle_hold got=%b want=1", rdy4); end
    endtask

    task automatic test_reset_mid;
        int lat;
        v4 = 1'b1; din4 = p4(3, 1, 4, 2); d4 = 1'b0;
        step;
        v4 = 1'b0;
        step;
        #2 reset = 1'b1;
        #1;
        total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b want=0", rdy4); end
        total++; if (dn4 !== 1'b0) begin bad++; $display("FAIL mid_done got=%b want=0", dn4); end
        total++; if (dout4 !== 32'h0) begin bad++; $display("FAIL mid_data got=%h want=0", dout4); end
        step;
        reset = 1'b0;
        #1;
        total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL mid_rel_ready got=%b want=1", rdy4); end
        total++; if (dout4 !== 32'h0) begin bad++; $display("FAIL mid_rel_data got=%h want=0", dout4); end
        step;
        sort4(p4(2, 3, 1, 0), 1'b0, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL mid_new_latency got=%0d want=3", lat); end
        total++; if (dout4 !== p4(0, 1, 2, 3)) begin bad++; $display("FAIL mid_new_data got=%h want=%h", dout4, p4(0, 1, 2, 3)); end
        ack4;
    endtask

    task automatic test_throughput;
        logic [63:0] q[$];
        logic [63:0] exp;
        int b = 0, got = 0, cyc = 0, last = 0;
        logic was;
        din8 = mk8(0); d8 = 1'($urandom_range(0, 1)); v8 = 1'b1; a8 = 1'b1;
        while (got < 200 && cyc < 2000) begin
            was = rdy8;
            step;
            cyc++;
            if (was) begin
                q.push_back(ref8(din8, d8));
                b++;
                din8 = mk8(b);
                d8 = 1'($urandom_range(0, 1));
            end
            if (dn8) begin
                exp = (q.size() > 0) ? q.pop_front() : 'x;
                total++; if (dout8 !== exp) begin bad++; $display("FAIL stream_data blk%0d got=%h want=%h", got, dout8, exp); end
                if (got > 0) begin
                    total++; if (cyc - last !== 8) begin bad++; $display("FAIL stream_period blk%0d got=%0d want=8", got, cyc - last); end
                end
                last = cyc;
                got++;
            end
        end
        total++; if (got !== 200) begin bad++; $display("FAIL stream_count got=%0d want=200", got); end
        v8 = 1'b0; a8 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_ascending;
        test_back_to_back;
        test_equal;
        test_stall;
        test_reset_mid;
        test_throughput;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
